// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan debouncing and a 4-entry key FIFO.
// Rows are driven one at a time; a full scan is classified once per pass.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_ready,
    input  logic       key_pop,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [DW-1:0] div;
    logic [1:0]    row;
    logic          row_end;
    logic          scan_end;
    logic [11:0]   seen;
    logic [15:0]   scan;
    logic [4:0]    nkeys;
    logic [3:0]    code;

    logic [1:0] state;
    logic [1:0] state_n;
    logic [3:0] cand;
    logic [3:0] cand_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [3:0] rel;
    logic [3:0] rel_n;
    logic       push;

    logic [3:0] mem [4];
    logic [1:0] wp;
    logic [1:0] rp;
    logic [2:0] count;
    logic       pop;
    logic       full;
    logic       wr;
    logic       drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= cols;
            sync2 <= sync1;
        end
    end

    assign row_end  = (div == DIV_LAST);
    assign scan_end = row_end && (row == 2'd3);
    assign rows     = ~(4'b0001 << row);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            row <= 2'd0;
        end else if (row_end) begin
            div <= '0;
            row <= row + 2'd1;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Rows 0..2 are latched; row 3 joins them live at the scan-end sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen <= '0;
        end else if (row_end) begin
            case (row)
                2'd0:    seen[3:0]  <= ~sync2;
                2'd1:    seen[7:4]  <= ~sync2;
                2'd2:    seen[11:8] <= ~sync2;
                default: seen       <= seen;
            endcase
        end
    end

    assign scan = {~sync2, seen};

    always_comb begin
        nkeys = 5'd0;
        code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (scan[i]) begin
                nkeys = nkeys + 5'd1;
                code  = 4'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rel_n   = rel;
        push    = 1'b0;
        if (scan_end) begin
            case (state)
                S_IDLE: begin
                    if (nkeys == 5'd1) begin
                        cand_n = code;
                        if (DEB == 4'd1) begin
                            push    = 1'b1;
                            state_n = S_HELD;
                            cnt_n   = 4'd0;
                            rel_n   = 4'd0;
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (nkeys == 5'd1 && code == cand) begin
                        if (cnt + 4'd1 == DEB) begin
                            push    = 1'b1;
                            state_n = S_HELD;
                            cnt_n   = 4'd0;
                            rel_n   = 4'd0;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                S_HELD: begin
                    if (nkeys == 5'd0) begin
                        if (rel + 4'd1 == DEB) begin
                            state_n = S_IDLE;
                            rel_n   = 4'd0;
                        end else begin
                            rel_n = rel + 4'd1;
                        end
                    end else begin
                        rel_n = 4'd0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                    rel_n   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cand  <= 4'd0;
            cnt   <= 4'd0;
            rel   <= 4'd0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            rel   <= rel_n;
        end
    end

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop  = key_pop && (count != 3'd0);
    assign full = (count == 3'd4);
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= cand_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp       <= 2'd0;
            rp       <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                wp <= wp + 2'd1;
            end
            if (pop) begin
                rp <= rp + 2'd1;
            end
            count    <= count + {2'b00, wr} - {2'b00, pop};
            overflow <= drop | (overflow & ~ovf_clr);
        end
    end

    assign key_ready = (count != 3'd0);
    assign key_code  = key_ready ? mem[rp] : 4'h0;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scan tables plus random key patterns
// checked cycle by cycle against a scan-level behavioural model.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_pop = 1'b0;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [15:0] keys = 16'h0;

    int checks = 0;
    int errors = 0;

    int k;
    int q[$];
    bit m_ovf;
    bit held;
    int run;
    int run_code;
    int rel;

    typedef struct {
        logic [15:0] mask;
        int          reps;
        bit          pop;
        bit          clr;
        bit          ready;
        int          code;
        bit          ovf;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_ready(key_ready),
        .key_pop(key_pop),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    // Passive keypad: a pressed key shorts its row line to its column.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && keys[r*4+c]) begin
                    cols[c] = 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] kb(int c);
        logic [15:0] one;
        one = 16'h0001;
        return one << c;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d",
                     name, act, exp, k);
        end
    endtask

    task automatic model_edge();
        bit push;
        bit set;
        bit pop_v;
        int n;
        int c;
        push = 0;
        set  = 0;
        if (k % SCAN == SCAN - 1) begin
            n = $countones(keys);
            c = 0;
            for (int i = 0; i < 16; i++) if (keys[i]) c = i;
            if (!held) begin
                if (n == 1 && (run == 0 || c == run_code)) begin
                    run_code = c;
                    run++;
                    if (run == DB) begin
                        push = 1;
                        held = 1;
                        run  = 0;
                        rel  = 0;
                    end
                end else begin
                    run = 0;
                end
            end else if (n == 0) begin
                rel++;
                if (rel == DB) begin
                    held = 0;
                    rel  = 0;
                end
            end else begin
                rel = 0;
            end
        end
        pop_v = key_pop && q.size() > 0;
        if (pop_v) void'(q.pop_front());
        if (push) begin
            if (q.size() < 4) q.push_back(run_code);
            else set = 1;
        end
        if (set) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        k++;
    endtask

    task automatic tick();
        int r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        r = (k / SD) % 4;
        check("rows", rows, 15 ^ (1 << r));
        check("key_ready", key_ready, q.size() > 0);
        check("key_code", key_code, q.size() > 0 ? q[0] : 0);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        key_pop = 1'b0;
        ovf_clr = 1'b0;
        @(posedge clk);
        q.delete();
        m_ovf = 0;
        held  = 0;
        run   = 0;
        rel   = 0;
        k     = 0;
        @(negedge clk);
        check("rst_rows", rows, 14);
        check("rst_ready", key_ready, 0);
        check("rst_code", key_code, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
    endtask

    task automatic scan(logic [15:0] mask, int pop_at, int clr_at,
                        int len = SCAN);
        keys = mask;
        for (int i = 0; i < len; i++) begin
            key_pop = (i == pop_at);
            ovf_clr = (i == clr_at);
            tick();
        end
        key_pop = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic press(int c);
        scan(kb(c), -1, -1);
        scan(kb(c), -1, -1);
        scan(16'h0, -1, -1);
        scan(16'h0, -1, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", k);
        $fatal(1);
    end

    initial begin
        int hold;
        logic [15:0] mask;
        int sel;
        int pa;
        int ca;

        k = 0;
        tbl.push_back('{kb(9), 1, 0, 0, 0, 0, 0});
        tbl.push_back('{kb(9), 1, 0, 0, 1, 9, 0});
        tbl.push_back('{kb(9), 18, 0, 0, 1, 9, 0});
        tbl.push_back('{16'h0, 2, 1, 0, 0, 0, 0});
        tbl.push_back('{kb(9), 1, 0, 0, 0, 0, 0});
        tbl.push_back('{16'h0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{kb(9), 1, 0, 0, 0, 0, 0});
        tbl.push_back('{kb(9), 1, 0, 0, 1, 9, 0});
        tbl.push_back('{16'h0, 2, 1, 0, 0, 0, 0});
        tbl.push_back('{kb(0) | kb(15), 10, 0, 0, 0, 0, 0});
        tbl.push_back('{16'h0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{kb(5), 1, 0, 0, 0, 0, 0});
        tbl.push_back('{kb(5), 1, 0, 0, 1, 5, 0});
        tbl.push_back('{16'h0, 2, 1, 0, 0, 0, 0});
        tbl.push_back('{kb(1), 1, 0, 0, 0, 0, 0});
        tbl.push_back('{kb(1), 1, 0, 0, 1, 1, 0});
        tbl.push_back('{16'h0, 2, 0, 0, 1, 1, 0});
        for (int c = 2; c <= 4; c++) begin
            tbl.push_back('{kb(c), 2, 0, 0, 1, 1, 0});
            tbl.push_back('{16'h0, 2, 0, 0, 1, 1, 0});
        end
        tbl.push_back('{kb(5), 1, 0, 0, 1, 1, 0});
        tbl.push_back('{kb(5), 1, 0, 0, 1, 1, 1});
        tbl.push_back('{16'h0, 2, 0, 0, 1, 1, 1});
        tbl.push_back('{16'h0, 1, 1, 0, 1, 2, 1});
        tbl.push_back('{16'h0, 1, 1, 0, 1, 3, 1});
        tbl.push_back('{16'h0, 1, 1, 0, 1, 4, 1});
        tbl.push_back('{16'h0, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{16'h0, 1, 0, 1, 0, 0, 0});

        do_reset();
        for (int t = 0; t < tbl.size(); t++) begin
            for (int r = 0; r < tbl[t].reps; r++) begin
                scan(tbl[t].mask, tbl[t].pop ? 8 : -1, tbl[t].clr ? 8 : -1);
                check($sformatf("tbl%0d_ready", t), key_ready, tbl[t].ready);
                check($sformatf("tbl%0d_code", t), key_code, tbl[t].code);
                check($sformatf("tbl%0d_ovf", t), overflow, tbl[t].ovf);
            end
        end

        // Full FIFO: push of key 7 lands on the same edge as a pop.
        for (int c = 1; c <= 4; c++) press(c);
        scan(kb(7), -1, -1);
        scan(kb(7), SCAN - 1, -1);
        check("pp_ovf", overflow, 0);
        check("pp_head", key_code, 2);
        scan(16'h0, 8, -1);
        check("pp_pop3", key_code, 3);
        scan(16'h0, 8, -1);
        check("pp_pop4", key_code, 4);
        scan(16'h0, 8, -1);
        check("pp_pop7", key_code, 7);
        scan(16'h0, 8, -1);
        check("pp_empty", key_ready, 0);

        // Reset mid-confirm with two queued entries.
        do_reset();
        press(1);
        press(2);
        scan(kb(9), -1, -1);
        check("mr_fifo", key_ready, 1);
        scan(kb(9), -1, -1, 6);
        do_reset();
        scan(kb(9), -1, -1);
        check("mr_scan1", key_ready, 0);
        scan(kb(9), -1, -1);
        check("mr_scan2_ready", key_ready, 1);
        check("mr_scan2_code", key_code, 9);
        scan(16'h0, 8, -1);
        scan(16'h0, -1, -1);

        // Random key patterns against the behavioural model.
        do_reset();
        hold = 0;
        mask = 16'h0;
        for (int s = 0; s < 400; s++) begin
            if (hold == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 4) mask = 16'h0;
                else if (sel < 8) mask = kb($urandom_range(0, 15));
                else mask = kb($urandom_range(0, 15)) | kb($urandom_range(0, 15));
                hold = $urandom_range(1, 4);
            end
            hold--;
            if (s < 200) pa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1;
            else pa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : -1;
            ca = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1;
            scan(mask, pa, ca);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each row is driven (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE, default 4, consecutive identical full scans required to accept a press or release (range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port rows  output  4  keypad row drive, active-low, exactly one bit low at any time.
REQ-006 SHALL have port cols  input  4  keypad column sense, active-low, asynchronous (pulled up externally).
REQ-007 SHALL have port key_code  output  4  code at FIFO head, code = row*4 + col.
REQ-008 SHALL have port key_ready  output  1  high while FIFO non-empty.
REQ-009 SHALL have port key_pop  input  1  consumer pops head when high on a clock edge.
REQ-010 SHALL have port overflow  output  1  sticky, set when a key is lost to a full FIFO.
REQ-011 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-012 SHALL pass cols through a 2-flop synchronizer before any use.
REQ-013 SHALL hold each row low for SCAN_DIV cycles, rows 0,1,2,3, wrapping 3->0; one full scan = 4*SCAN_DIV cycles.
REQ-014 SHALL sample synchronized cols on the last cycle of each row period only.
REQ-015 SHALL classify each full scan at its row-3 sample as NONE (0 keys), SINGLE(code) (exactly 1 key), or MULTI (>1 key).
REQ-016 SHALL run FSM IDLE / CONFIRM / HELD, updated once per scan classification.
REQ-017 IDLE: SINGLE(c) -> cand=c, cnt=1, CONFIRM (if DEBOUNCE=1, push c and go HELD directly); NONE/MULTI -> stay IDLE.
REQ-018 CONFIRM: SINGLE(cand) -> cnt+1; on reaching DEBOUNCE push cand, go HELD; any other result -> IDLE, cnt=0, no push.
REQ-019 HELD: NONE -> rel+1, on reaching DEBOUNCE go IDLE; SINGLE/MULTI -> rel=0, stay; no auto-repeat, second key while holding first is ignored.
REQ-020 SHALL buffer accepted codes in a 4-entry FIFO, show-ahead: key_code valid combinationally with key_ready.
REQ-021 key_pop while key_ready SHALL remove head; key_pop while empty SHALL be ignored.
REQ-022 Push while full without same-cycle pop SHALL drop the code and set overflow; push with same-cycle pop while full SHALL succeed, no overflow.
REQ-023 Push while empty SHALL raise key_ready on the following cycle with key_code = pushed code.
REQ-024 key_code SHALL read 0 when FIFO empty.
REQ-025 ovf_clr SHALL clear overflow; simultaneous set and clear SHALL leave overflow set.
REQ-026 FIFO occupancy SHALL never exceed 4 nor wrap below 0; pointers wrap modulo 4.

Reset
REQ-027 rst_n low at a clock edge SHALL force rows=4'b1110, row index 0, divider 0, FSM IDLE, cnt=rel=0, synchronizer flops to 4'b1111, FIFO empty, key_ready=0, key_code=0, overflow=0.
REQ-028 Reset mid-scan or mid-debounce SHALL discard partial results; first classification occurs 4*SCAN_DIV cycles after release.

Verification (SCAN_DIV=4, DEBOUNCE=2 unless noted)
REQ-029 Hold key row2/col1 (model drives cols[1] low only while rows[2] low) from reset release -> key_ready rises by 2 scans + 3 cycles (<=35 cycles), key_code=9; exactly one entry after 20 scans of holding.
REQ-030 Bounce: key 9 present scan 1, absent scan 2, present scans 3-4 -> no push until end of scan 4; single entry code 9.
REQ-031 Two keys (codes 0 and 15) held together for 10 scans -> no push; release both, press 5 -> code 5 pushed.
REQ-032 Press/release keys 1,2,3,4,5 sequentially, no pops -> FIFO holds 1,2,3,4, overflow=1; pops return 1,2,3,4 then key_ready=0; ovf_clr -> overflow=0.
REQ-033 FIFO full, push of key 7 coincident with key_pop -> overflow stays 0, order preserved with 7 at tail.
REQ-034 rst_n low for 1 cycle mid-CONFIRM and with 2 FIFO entries -> FIFO empty, rows=4'b1110, held key re-accepted only after DEBOUNCE full scans post-reset.
